// File: rtl/drm_bist_pkg.sv
// Shared types and helpers for the DRM BIST controller.
// Contents: FSM state enum, P0/P1 march pattern functions, read-latency legality check.
package drm_bist_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 1152;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_RD0,
    ST_DRAIN0,
    ST_WR1,
    ST_RD1,
    ST_DRAIN1,
    ST_DONE
  } bist_state_e;

  // P0(a) = all-ones - a, which is ~a once a is zero-extended to the word width.
  function automatic logic [MAX_DATA_WIDTH-1:0] pat0(input logic [MAX_DATA_WIDTH-1:0] a);
    return ~a;
  endfunction

  // P1(a) = ~P0(a).
  function automatic logic [MAX_DATA_WIDTH-1:0] pat1(input logic [MAX_DATA_WIDTH-1:0] a);
    return ~pat0(a);
  endfunction

  // Only unregistered (1) or registered (2) RAM read outputs are supported.
  function automatic bit rd_latency_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/drm_bist_if.sv
// Simple-dual-port RAM port bundle driven by the BIST controller.
// master: controller side (drives write port and read address, receives read data).
// slave : RAM side.
interface drm_bist_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 20
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/drm_bist_chk.sv
// Read-back checker: delays expected word/address/valid by RD_LATENCY cycles,
// compares against RAM read data, keeps a saturating error count and the first failing address.
// Ports: clk, rst_n; i_clear (start of test), i_rd_vld/i_rd_addr/i_exp_data (issued read),
// i_rd_data (RAM output); o_err_cnt, o_first_err_addr (registered), o_err_seen_c (comb: any error so far incl. this cycle).
module drm_bist_chk
  import drm_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 20,
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned ERR_CNT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_rd_vld,
  input  logic [ADDR_WIDTH-1:0]    i_rd_addr,
  input  logic [DATA_WIDTH-1:0]    i_exp_data,
  input  logic [DATA_WIDTH-1:0]    i_rd_data,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
  output logic [ADDR_WIDTH-1:0]    o_first_err_addr,
  output logic                     o_err_seen_c
);

  logic                     r_vld  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0]    r_addr [RD_LATENCY];
  logic [DATA_WIDTH-1:0]    r_exp  [RD_LATENCY];
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic [ADDR_WIDTH-1:0]    r_first_err_addr;
  logic                     w_mismatch;

  // First pipeline stage captures the read as it is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld[0]  <= 1'b0;
      r_addr[0] <= '0;
      r_exp[0]  <= '0;
    end else begin
      r_vld[0]  <= i_rd_vld;
      r_addr[0] <= i_rd_addr;
      r_exp[0]  <= i_exp_data;
    end
  end

  // Remaining stages line the expectation up with the RAM output register.
  for (genvar g = 1; g < RD_LATENCY; g++) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld[g]  <= 1'b0;
        r_addr[g] <= '0;
        r_exp[g]  <= '0;
      end else begin
        r_vld[g]  <= r_vld[g-1];
        r_addr[g] <= r_addr[g-1];
        r_exp[g]  <= r_exp[g-1];
      end
    end
  end

  assign w_mismatch   = r_vld[RD_LATENCY-1] && (i_rd_data != r_exp[RD_LATENCY-1]);
  assign o_err_seen_c = (r_err_cnt != '0) || w_mismatch;

  // Saturating count; a zero count means this mismatch is the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else if (i_clear) begin
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else if (w_mismatch) begin
      if (r_err_cnt == '0) r_first_err_addr <= r_addr[RD_LATENCY-1];
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign o_err_cnt        = r_err_cnt;
  assign o_first_err_addr = r_first_err_addr;

endmodule

// File: rtl/drm_bist_ctrl.sv
// Two-pass march BIST controller for one simple-dual-port DRM instance.
// Ports: clk, rst_n, start (level, sampled in IDLE); busy, done, pass, err_cnt, first_err_addr;
// ram (master modport): wr_en/wr_addr/wr_data, rd_addr out, rd_data in.
module drm_bist_ctrl
  import drm_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 20,
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned ERR_CNT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  drm_bist_if.master               ram
);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("drm_bist_ctrl: RD_LATENCY must be 1 or 2");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_DRAIN = ADDR_WIDTH'(RD_LATENCY - 1);

  bist_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_rd_vld;
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  logic                  w_launch;
  logic                  w_addr_last;
  logic                  w_drain_last;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0] w_exp_data;
  logic                  w_err_seen;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a, input logic inv);
    logic [MAX_DATA_WIDTH-1:0] w;
    w = inv ? pat1(MAX_DATA_WIDTH'(a)) : pat0(MAX_DATA_WIDTH'(a));
    return DATA_WIDTH'(w);
  endfunction

  assign w_launch     = (r_state == ST_IDLE) && start;
  assign w_addr_last  = (r_addr == '1);
  assign w_drain_last = (r_addr == LAST_DRAIN);
  assign w_addr_next  = r_addr + ADDR_WIDTH'(1);
  // Expected word tracks the read address register, so it is aligned with rd_addr.
  assign w_exp_data   = pattern(r_rd_addr, r_state == ST_RD1);

  // FSM: each transition also loads the port registers for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_WR0;
            r_addr    <= '0;
            r_pass    <= 1'b0;
            r_busy    <= 1'b1;
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= pattern('0, 1'b0);
          end
        end
        ST_WR0, ST_WR1: begin
          if (w_addr_last) begin
            r_state   <= (r_state == ST_WR0) ? ST_RD0 : ST_RD1;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_vld  <= 1'b1;
            r_rd_addr <= '0;
          end else begin
            r_addr    <= w_addr_next;
            r_wr_addr <= w_addr_next;
            r_wr_data <= pattern(w_addr_next, r_state == ST_WR1);
          end
        end
        ST_RD0, ST_RD1: begin
          if (w_addr_last) begin
            r_state   <= (r_state == ST_RD0) ? ST_DRAIN0 : ST_DRAIN1;
            r_addr    <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_addr <= '0;
          end else begin
            r_addr    <= w_addr_next;
            r_rd_addr <= w_addr_next;
          end
        end
        ST_DRAIN0: begin
          if (w_drain_last) begin
            r_state   <= ST_WR1;
            r_addr    <= '0;
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= pattern('0, 1'b1);
          end else begin
            r_addr <= w_addr_next;
          end
        end
        ST_DRAIN1: begin
          if (w_drain_last) begin
            // The last compare lands in this cycle, so fold it in directly.
            r_state <= ST_DONE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !w_err_seen;
          end else begin
            r_addr <= w_addr_next;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  drm_bist_chk #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .RD_LATENCY   (RD_LATENCY),
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_chk (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (w_launch),
    .i_rd_vld        (r_rd_vld),
    .i_rd_addr       (r_rd_addr),
    .i_exp_data      (w_exp_data),
    .i_rd_data       (ram.rd_data),
    .o_err_cnt       (err_cnt),
    .o_first_err_addr(first_err_addr),
    .o_err_seen_c    (w_err_seen)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign ram.wr_en   = r_wr_en;
  assign ram.wr_addr = r_wr_addr;
  assign ram.wr_data = r_wr_data;
  assign ram.rd_addr = r_rd_addr;

endmodule

// File: tb/tb_drm_bist_ctrl.sv
// Self-checking bench for drm_bist_ctrl: table of directed runs, randomized read-fault runs
// checked against an arithmetic model, and hand-written reset / held-start sequences.
`timescale 1ns/1ps
module tb_drm_bist_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 20;
  localparam int unsigned D  = 256;
  localparam int LAT1 = 2 * (2 * 256 + 1);  // edges from launch to done sample, RD_LATENCY=1
  localparam int LAT2 = 2 * (2 * 256 + 2);

  logic clk;
  logic rst_n, start1, start2;
  logic busy1, done1, pass1, busy2, done2, pass2;
  logic [2:0]    ec1, ec2;
  logic [AW-1:0] fa1, fa2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  drm_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  drm_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

  drm_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(ec1), .first_err_addr(fa1), .ram(if1));

  drm_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(ec2), .first_err_addr(fa2), .ram(if2));

  // Read-side fault injection for RAM 1
  bit            f_en, f_all;
  int            f_addr;
  logic [DW-1:0] f_sa0, f_sa1;
  int            ram1_lat;

  function automatic logic [DW-1:0] apply_fault(logic [DW-1:0] d, int a);
    if (f_en && (f_all || a == f_addr)) return (d & ~f_sa0) | f_sa1;
    return d;
  endfunction

  // Pattern from its definition: (all-ones - a) mod 2**DW, pass 1 is its complement.
  function automatic logic [DW-1:0] pat(int a, int p);
    logic [DW-1:0] w;
    w = DW'((1 << DW) - 1 - a);
    return (p != 0) ? ~w : w;
  endfunction

  logic [DW-1:0] mem1 [D];
  logic [DW-1:0] mem2 [D];
  logic [DW-1:0] q1, q1d, q2, q2d;
  int bad_wr;

  always @(posedge clk) begin
    if (if1.wr_en) mem1[if1.wr_addr] <= if1.wr_data;
    q1  <= apply_fault(mem1[if1.rd_addr], int'(if1.rd_addr));
    q1d <= q1;
  end
  assign if1.rd_data = (ram1_lat == 2) ? q1d : q1;

  always @(posedge clk) begin
    if (if2.wr_en) mem2[if2.wr_addr] <= if2.wr_data;
    q2  <= mem2[if2.rd_addr];
    q2d <= q2;
  end
  assign if2.rd_data = q2d;

  // Every write must carry one of the two march patterns for its address.
  initial bad_wr = 0;
  always @(posedge clk)
    if (rst_n && if1.wr_en &&
        if1.wr_data !== pat(int'(if1.wr_addr), 0) && if1.wr_data !== pat(int'(if1.wr_addr), 1))
      bad_wr <= bad_wr + 1;

  int sel;
  wire           busy_m = (sel == 2) ? busy2 : busy1;
  wire           done_m = (sel == 2) ? done2 : done1;
  wire           pass_m = (sel == 2) ? pass2 : pass1;
  wire [2:0]     ec_m   = (sel == 2) ? ec2 : ec1;
  wire [AW-1:0]  fa_m   = (sel == 2) ? fa2 : fa1;

  int errors, checks;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 2) start2 = v; else start1 = v;
  endtask

  task automatic set_fault(input bit en, input bit all, input int addr, input int b, input bit sa1);
    f_en = en; f_all = all; f_addr = addr;
    f_sa0 = '0; f_sa1 = '0;
    if (sa1) f_sa1 = DW'(1) << b; else f_sa0 = DW'(1) << b;
  endtask

  // Error statistics predicted straight from the march definition and the injected fault.
  task automatic model(output int cnt, output int first, output bit ok);
    logic [DW-1:0] w;
    cnt = 0; first = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < int'(D); a++) begin
        w = pat(a, p);
        if (apply_fault(w, a) !== w) begin
          if (cnt == 0) first = a;
          if (cnt < 7) cnt++;
        end
      end
    ok = (cnt == 0);
  endtask

  // One full test on DUT s: done timing, single done pulse, busy length and result outputs.
  task automatic run_test(input int s, input int lat, input bit e_pass, input int e_cnt,
                          input int e_first, input bit noise, input string nm);
    int done_k, n_done, n_busy, got_cnt, got_first;
    logic got_pass;
    done_k = -1; n_done = 0; n_busy = 0; got_cnt = -1; got_first = -1; got_pass = 1'bx;
    sel = s;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    if (busy_m) n_busy++;
    for (int k = 1; k <= lat + 3; k++) begin
      if (noise && k < lat - 4) set_start(s, 1'($urandom_range(0, 1)));
      else set_start(s, 1'b0);
      @(posedge clk); #1;
      if (busy_m) n_busy++;
      if (done_m) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k; got_pass = pass_m; got_cnt = int'(ec_m); got_first = int'(fa_m);
        end
      end
    end
    chk({nm, " done_cycle"}, done_k, lat);
    chk({nm, " done_count"}, n_done, 1);
    chk({nm, " busy_cycles"}, n_busy, lat);
    chk({nm, " pass"}, got_pass, e_pass);
    chk({nm, " err_cnt"}, got_cnt, e_cnt);
    chk({nm, " first_err_addr"}, got_first, e_first);
    chk({nm, " pass_held"}, pass_m, e_pass);
  endtask

  typedef struct {
    int    s;
    int    rlat;
    bit    fen;
    bit    fall;
    int    faddr;
    int    fbit;
    bit    fsa1;
    int    lat;
    bit    e_pass;
    int    e_cnt;
    int    e_first;
    string name;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cnt, first, k, n_done, bad;
    bit ok;
    int done_t [$];

    errors = 0; checks = 0; sel = 1;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; ram1_lat = 1;
    set_fault(1'b0, 1'b0, 0, 0, 1'b0);

    vecs[0] = '{1, 1, 0, 0, 0,    0, 0, LAT1, 1, 0, 0,    "clean_l1"};
    vecs[1] = '{2, 2, 0, 0, 0,    0, 0, LAT2, 1, 0, 0,    "clean_l2"};
    vecs[2] = '{1, 2, 0, 0, 0,    0, 0, LAT1, 0, 7, 1,    "lat_mismatch"};
    vecs[3] = '{1, 1, 1, 0, 16,   0, 1, LAT1, 0, 1, 16,   "sa1_bit0_addr10"};
    vecs[4] = '{1, 1, 1, 1, 0,    5, 0, LAT1, 0, 7, 0,    "sa0_bit5_all"};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_dut1", {busy1, done1, pass1, ec1, fa1, if1.wr_en, if1.wr_addr, if1.wr_data, if1.rd_addr}, 0);
    chk("reset_outputs_dut2", {busy2, done2, pass2, ec2, fa2, if2.wr_en, if2.wr_addr, if2.wr_data, if2.rd_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      ram1_lat = vecs[i].rlat;
      set_fault(vecs[i].fen, vecs[i].fall, vecs[i].faddr, vecs[i].fbit, vecs[i].fsa1);
      run_test(vecs[i].s, vecs[i].lat, vecs[i].e_pass, vecs[i].e_cnt, vecs[i].e_first, 1'b0, vecs[i].name);
    end

    ram1_lat = 1;
    for (int i = 0; i < 6; i++) begin
      set_fault($urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, D - 1)),
                int'($urandom_range(0, DW - 1)), 1'($urandom_range(0, 1)));
      model(cnt, first, ok);
      run_test(1, LAT1, ok, cnt, first, 1'(i % 2), $sformatf("rand%0d", i));
    end

    // Reset in the middle of a failing test, then a clean rerun.
    set_fault(1'b1, 1'b1, 0, 5, 1'b0);
    sel = 1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (299) @(posedge clk);
    #1;
    chk("midtest_err_cnt", ec1, 7);
    chk("midtest_busy", busy1, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {busy1, done1, pass1, ec1, fa1, if1.wr_en, if1.wr_addr, if1.wr_data, if1.rd_addr}, 0);
    n_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done1) n_done++;
    end
    chk("midreset_no_done", n_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_fault(1'b0, 1'b0, 0, 0, 1'b0);
    run_test(1, LAT1, 1'b1, 0, 0, 1'b0, "after_reset");

    bad = 0;
    for (int a = 0; a < int'(D); a++) if (mem1[a] !== pat(a, 1)) bad++;
    chk("final_mem_p1_words_bad", bad, 0);

    // start held: back-to-back tests separated by one IDLE cycle.
    sel = 1;
    start1 = 1'b1;
    @(posedge clk); #1;
    k = 0;
    while (k < 2 * LAT1 + 6) begin
      @(posedge clk); #1;
      k++;
      if (done1) begin
        done_t.push_back(k);
        chk($sformatf("held_pass_at_%0d", k), pass1, 1);
      end
      if (k == 2 * LAT1 + 2) start1 = 1'b0;
    end
    chk("held_done_count", done_t.size(), 2);
    if (done_t.size() == 2) begin
      chk("held_first_done", done_t[0], LAT1);
      chk("held_second_done", done_t[1], 2 * LAT1 + 2);
    end
    chk("held_idle_after", busy1, 0);

    chk("bad_pattern_writes", bad_wr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
